// File: rtl/fp_adder_pkg.sv
// Shared encodings for the FP adder datapath: shifter modes and shifter FSM states.
package fp_adder_pkg;

  localparam logic [1:0] MODE_SRL  = 2'b00;
  localparam logic [1:0] MODE_SLL  = 2'b01;
  localparam logic [1:0] MODE_NORM = 2'b10;
  localparam logic [1:0] MODE_SRA  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// One shifter step: moves value by s (<= STEP) positions, reports the bits lost off
// the LSB end and the leading-zero count within the top STEP bits.
module shift_step_unit
  import fp_adder_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int STEP  = 4,
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [SW-1:0]    s,
  input  logic [1:0]       mode,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted,
  output logic             out_or,
  output logic [SW-1:0]    lz_top
);

  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] fill_mask;
  logic             found;

  assign low_mask  = ~({WIDTH{1'b1}} << s);
  assign fill_mask = ~({WIDTH{1'b1}} >> s);
  assign out_or    = |(value & low_mask);

  always_comb begin
    shifted = value << s;
    if (mode == MODE_SRL || mode == MODE_SRA)
      shifted = (value >> s) | (fill ? fill_mask : '0);
  end

  // Leading zeros are only looked for within one step's reach.
  always_comb begin
    lz_top = '0;
    found  = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (!found) begin
        if (value[WIDTH-1-i]) found = 1'b1;
        else                  lz_top = lz_top + SW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_norm_shifter.sv
// Multi-bit sequential shifter for the FP adder: aligns (right, sticky), shifts left,
// shifts arithmetic right, or normalises left reporting the total shift.
module seq_norm_shifter
  import fp_adder_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8,
  parameter int STEP  = 4
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Load,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] Data,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Result,
  output logic             Sticky,
  output logic [CNT_W-1:0] Shift_total,
  output logic             Zero,
  output logic             shift_enable,
  output logic             Done
);

  localparam int SW = $clog2(STEP + 1);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state;
  logic [1:0]       mode_r;
  logic             fill;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count_c;
  logic [CNT_W-1:0] lz_c;
  logic [CNT_W-1:0] s_amt;
  logic [CNT_W-1:0] next_rem;
  logic [SW-1:0]    step_s;
  logic [SW-1:0]    lz_top;
  logic [WIDTH-1:0] shifted;
  logic             out_or;
  logic             right_mode;

  assign count_c    = (Count > WIDTH_C) ? WIDTH_C : Count;
  assign lz_c       = CNT_W'(lz_top);
  assign right_mode = (mode_r == MODE_SRL) || (mode_r == MODE_SRA);
  assign next_rem   = remaining - s_amt;
  assign step_s     = SW'(s_amt);

  // Normalise never shifts past the first 1 or past the remaining cap.
  always_comb begin
    s_amt = (remaining < STEP_C) ? remaining : STEP_C;
    if (mode_r == MODE_NORM)
      s_amt = (lz_c < remaining) ? lz_c : remaining;
  end

  shift_step_unit #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .value   (Result),
    .s       (step_s),
    .mode    (mode_r),
    .fill    (fill),
    .shifted (shifted),
    .out_or  (out_or),
    .lz_top  (lz_top)
  );

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      state        <= ST_IDLE;
      mode_r       <= MODE_SRL;
      fill         <= 1'b0;
      remaining    <= '0;
      Result       <= '0;
      Sticky       <= 1'b0;
      Shift_total  <= '0;
      Zero         <= 1'b0;
      shift_enable <= 1'b0;
      Done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Load) begin
            Result      <= Data;
            Sticky      <= 1'b0;
            Shift_total <= '0;
            Zero        <= 1'b0;
            mode_r      <= Mode;
            fill        <= (Mode == MODE_SRA) & Data[WIDTH-1];
            if (Mode == MODE_NORM) begin
              remaining <= Count;
              if (Data == '0) begin
                Zero  <= 1'b1;
                state <= ST_DONE;
                Done  <= 1'b1;
              end else if (Data[WIDTH-1] || Count == '0) begin
                state <= ST_DONE;
                Done  <= 1'b1;
              end else begin
                state        <= ST_SHIFT;
                shift_enable <= 1'b1;
              end
            end else begin
              remaining <= count_c;
              if (count_c == '0) begin
                state <= ST_DONE;
                Done  <= 1'b1;
              end else begin
                state        <= ST_SHIFT;
                shift_enable <= 1'b1;
              end
            end
          end
        end
        ST_SHIFT: begin
          Result      <= shifted;
          Sticky      <= Sticky | (right_mode & out_or);
          remaining   <= next_rem;
          Shift_total <= Shift_total + s_amt;
          if (next_rem == '0 || (mode_r == MODE_NORM && shifted[WIDTH-1])) begin
            state        <= ST_DONE;
            shift_enable <= 1'b0;
            Done         <= 1'b1;
          end
        end
        ST_DONE: begin
          Done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state        <= ST_IDLE;
          shift_enable <= 1'b0;
          Done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_norm_shifter.sv
// Bench for seq_norm_shifter: directed cases plus random operations against a
// whole-word arithmetic model of each shift mode.
module tb_seq_norm_shifter;

  localparam int W  = 24;
  localparam int CW = 8;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic          load = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  data = '0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  result;
  logic          sticky;
  logic [CW-1:0] shift_total;
  logic          zero;
  logic          shift_enable;
  logic          done;

  int total = 0;
  int bad   = 0;

  seq_norm_shifter #(.WIDTH(W), .CNT_W(CW), .STEP(ST)) dut (
    .Clk          (clk),
    .Clear        (clear_n),
    .Load         (load),
    .Mode         (mode),
    .Data         (data),
    .Count        (count),
    .Result       (result),
    .Sticky       (sticky),
    .Shift_total  (shift_total),
    .Zero         (zero),
    .shift_enable (shift_enable),
    .Done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: shift the operand once by the full amount.
  task automatic model(input logic [1:0] m, input logic [W-1:0] d, input logic [CW-1:0] c,
                       output logic [W-1:0] r, output logic st, output logic [CW-1:0] tot,
                       output logic z, output int cyc);
    int n;
    int lz;
    logic found;
    logic signed [W-1:0] sd;
    n   = (int'(c) > W) ? W : int'(c);
    st  = 1'b0;
    z   = 1'b0;
    sd  = d;
    r   = d;
    case (m)
      2'b00: begin
        r = d >> n;
        for (int i = 0; i < n; i++) st |= d[i];
      end
      2'b01: r = d << n;
      2'b11: begin
        r = W'(sd >>> n);
        for (int i = 0; i < n; i++) st |= d[i];
      end
      default: begin
        lz = 0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
          if (!found) begin
            if (d[i]) found = 1'b1;
            else      lz++;
          end
        end
        if (d == '0) begin
          z = 1'b1;
          n = 0;
        end else begin
          n = (lz < int'(c)) ? lz : int'(c);
        end
        r = d << n;
      end
    endcase
    tot = CW'(n);
    cyc = (n + ST - 1) / ST;
  endtask

  task automatic run_op(input logic [1:0] m, input logic [W-1:0] d, input logic [CW-1:0] c,
                        input bit poke);
    logic [W-1:0]  er;
    logic          est;
    logic [CW-1:0] etot;
    logic          ez;
    int            ecyc;
    int            cyc;
    bit            seen;
    model(m, d, c, er, est, etot, ez, ecyc);
    @(negedge clk);
    load  = 1'b1;
    mode  = m;
    data  = d;
    count = c;
    @(negedge clk);
    load  = 1'b0;
    data  = ~d;
    count = CW'($urandom);
    mode  = 2'($urandom);
    cyc   = 0;
    seen  = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (k > 0) begin
        @(negedge clk);
        load = 1'b0;
      end
      if (done) seen = 1'b1;
      else if (shift_enable) begin
        cyc++;
        if (poke && cyc == 1) load = 1'b1;
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("shift_cycles", 64'(cyc), 64'(ecyc));
    chk("result", 64'(result), 64'(er));
    chk("sticky", 64'(sticky), 64'(est));
    chk("shift_total", 64'(shift_total), 64'(etot));
    chk("zero", 64'(zero), 64'(ez));
    @(negedge clk);
    load = 1'b0;
    chk("done_pulse", 64'(done), 64'(0));
    chk("result_hold", 64'(result), 64'(er));
  endtask

  initial begin
    bit seen;
    logic [W-1:0] rd;
    logic [CW-1:0] rc;
    logic [1:0] rm;
    int sel;

    #2;
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(shift_enable), 64'(0));
    chk("rst_total", 64'(shift_total), 64'(0));
    @(negedge clk);
    clear_n = 1'b1;

    run_op(2'b00, 24'h0F0FFE, 8'd6, 1'b0);
    run_op(2'b01, 24'hA15FC2, 8'd4, 1'b0);
    run_op(2'b00, 24'hFF00FE, 8'd0, 1'b0);
    run_op(2'b00, 24'h5ABCDE, 8'd30, 1'b0);
    run_op(2'b11, 24'h800001, 8'd30, 1'b0);
    run_op(2'b10, 24'h000123, 8'd255, 1'b0);
    run_op(2'b10, 24'h000123, 8'd8, 1'b0);
    run_op(2'b10, 24'h000000, 8'd255, 1'b0);
    run_op(2'b10, 24'h812345, 8'd255, 1'b0);
    run_op(2'b10, 24'h000F00, 8'd0, 1'b0);
    run_op(2'b11, 24'h9ABCDE, 8'd7, 1'b0);
    run_op(2'b00, 24'h3C3C3C, 8'd20, 1'b1);

    // Abort: drop Clear during the second SHIFT cycle of a long left shift.
    @(negedge clk);
    load  = 1'b1;
    mode  = 2'b01;
    data  = 24'h7FFFFF;
    count = 8'd20;
    @(negedge clk);
    load = 1'b0;
    chk("abort_busy1", 64'(shift_enable), 64'(1));
    @(negedge clk);
    #1;
    clear_n = 1'b0;
    load    = 1'b1;
    #1;
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_sticky", 64'(sticky), 64'(0));
    chk("abort_total", 64'(shift_total), 64'(0));
    chk("abort_zero", 64'(zero), 64'(0));
    chk("abort_busy", 64'(shift_enable), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    chk("clear_load_ignored", 64'(shift_enable), 64'(0));
    chk("clear_load_result", 64'(result), 64'(0));
    load    = 1'b0;
    clear_n = 1'b1;
    seen    = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || shift_enable) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'(0));

    for (int t = 0; t < 60; t++) begin
      rm  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel == 0)      rd = '0;
      else if (sel == 1) rd = W'($urandom) | 24'h800000;
      else if (sel <= 4) rd = W'($urandom >> $urandom_range(8, 31));
      else               rd = W'($urandom);
      rc = ($urandom_range(0, 5) == 0) ? 8'd255 : CW'($urandom_range(0, 35));
      run_op(rm, rd, rc, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
